// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage.
// Takes the EX/MEM register outputs and either retires ALU ops straight into the
// MEM/WB register (latency 1) or runs a data-memory transaction (store: REQ;
// load: REQ then WAIT_RD) before retiring. stall holds EX/MEM while busy.
//
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN
//   defined   : a load/store with alu_result[1:0] != 0 issues no request and
//               retires next edge with wb_reg_write=0 and a misalign_trap pulse.
//   undefined : misalign_trap tied 0; low address bits are dropped.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid, mem_write_en,
//   mem_to_reg, reg_write,
//   alu_result, read_data_2, rd_num EX/MEM register contents
//   stall                           high while a transaction is in flight
//   dmem_req/we/addr/wdata          data-memory request channel
//   dmem_ready                      request accepted when dmem_req & dmem_ready
//   dmem_rvalid/rdata               data-memory read return
//   wb_*                            MEM/WB register; wb_valid pulses per retire
//   misalign_trap                   one-cycle pulse on a trapped access
module mem_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              mem_write_en,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic [REG_W-1:0]  rd_num,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_W-1:0]  wb_rd_num,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic              misalign_trap
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitRd} state_e;

  state_e state_q, state_d;

  // Pending transaction, latched on entry to StReq.
  logic [DATA_W-1:0] addr_q, wdata_q, alu_q;
  logic              we_q, reg_write_q, mem_to_reg_q;
  logic [REG_W-1:0]  rd_q;

  logic memop, trap_hit;
  logic latch_op, retire_in, retire_pend, load_done;

  assign memop = in_valid & (mem_write_en | mem_to_reg);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign trap_hit = memop & (alu_result[1:0] != 2'b00);
`else
  assign trap_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    latch_op    = 1'b0;
    retire_in   = 1'b0;
    retire_pend = 1'b0;
    load_done   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (memop && !trap_hit) begin
          latch_op = 1'b1;
          state_d  = StReq;
        end else if (in_valid) begin
          // ALU op, or a trapped access, retires directly from the inputs.
          retire_in = 1'b1;
        end
      end
      StReq: begin
        if (dmem_ready) begin
          if (we_q) begin
            retire_pend = 1'b1;
            state_d     = StIdle;
          end else begin
            state_d = StWaitRd;
          end
        end
      end
      StWaitRd: begin
        if (dmem_rvalid) begin
          retire_pend = 1'b1;
          load_done   = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      alu_q        <= '0;
      we_q         <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      rd_q         <= '0;
    end else begin
      state_q <= state_d;
      if (latch_op) begin
        addr_q       <= {alu_result[DATA_W-1:2], 2'b00};
        wdata_q      <= read_data_2;
        alu_q        <= alu_result;
        we_q         <= mem_write_en;
        reg_write_q  <= reg_write;
        mem_to_reg_q <= mem_to_reg & ~mem_write_en;  // store wins
        rd_q         <= rd_num;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_rd_num     <= '0;
      wb_alu_result <= '0;
      wb_mem_data   <= '0;
    end else begin
      wb_valid <= retire_in | retire_pend;
      if (retire_in) begin
        wb_reg_write  <= reg_write & ~trap_hit;
        wb_mem_to_reg <= mem_to_reg & ~mem_write_en;
        wb_rd_num     <= rd_num;
        wb_alu_result <= alu_result;
      end else if (retire_pend) begin
        wb_reg_write  <= reg_write_q;
        wb_mem_to_reg <= mem_to_reg_q;
        wb_rd_num     <= rd_q;
        wb_alu_result <= alu_q;
      end
      if (load_done) begin
        wb_mem_data <= dmem_rdata;
      end
    end
  end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_trap <= 1'b0;
    end else begin
      misalign_trap <= retire_in & trap_hit;
    end
  end
`else
  assign misalign_trap = 1'b0;
`endif

  assign stall      = (state_q != StIdle);
  assign dmem_req   = (state_q == StReq);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule
